// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scanner: digit/segment widths and
// active-low segment patterns ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sseg_scanner_if.sv
// Link between the BCD counter chain (master) and the display scanner (slave).
interface sseg_scanner_if
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   logic [DIGIT_W*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]         dp_in;
   logic                          blank_lz;
   logic [SEG_W-1:0]              seg;
   logic                          dp;
   logic [NUM_DIGITS-1:0]         an;

   modport master (output digits, dp_in, blank_lz, input seg, dp, an);
   modport slave  (input digits, dp_in, blank_lz, output seg, dp, an);
endinterface

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show "-".
module bcd_to_sseg
   import sseg_pkg::*;
(
   input  logic [DIGIT_W-1:0] bcd,
   output logic [SEG_W-1:0]   seg
);
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/sseg_scanner.sv
// Multiplexed common-anode display driver with per-frame snapshot, leading-zero
// blanking and an anode dead time at the start of each digit slot.
module sseg_scanner
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2
)(
   input logic           clk,
   input logic           reset,
   sseg_scanner_if.slave bus
);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]                   cnt;
   logic [IDX_W-1:0]                   idx;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap_digits;
   logic [NUM_DIGITS-1:0]              snap_dp;
   logic                               snap_blz;
   logic                               frame_end;
   logic [NUM_DIGITS-1:0]              lz_zero;
   logic                               lz_run;
   logic [DIGIT_W-1:0]                 cur_digit;
   logic [SEG_W-1:0]                   cur_seg;
   logic [SEG_W-1:0]                   seg_next, seg_q;
   logic                               dp_next, dp_q;
   logic [NUM_DIGITS-1:0]              an_next, an_q;

   assign frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_digits <= '0;
         snap_dp     <= '0;
         snap_blz    <= 1'b0;
      end else if (frame_end) begin
         snap_digits <= bus.digits;
         snap_dp     <= bus.dp_in;
         snap_blz    <= bus.blank_lz;
      end
   end

   // lz_zero[i] is set when snapshot digits i..NUM_DIGITS-1 are all zero
   always_comb begin
      lz_run  = 1'b1;
      lz_zero = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         lz_run = lz_run & (snap_digits[NUM_DIGITS-1-j] == '0);
         lz_zero[NUM_DIGITS-1-j] = lz_run;
      end
   end

   assign cur_digit = snap_digits[idx];

   bcd_to_sseg u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   always_comb begin
      an_next  = '1;
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
      if (cnt >= CNT_DEAD) begin
         an_next[idx] = 1'b0;
         seg_next     = (snap_blz && (idx != '0) && lz_zero[idx]) ? SEG_BLANK : cur_seg;
         dp_next      = ~snap_dp[idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_q  <= '1;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_next;
         seg_q <= seg_next;
         dp_q  <= dp_next;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
endmodule

// File: doc/sseg_scanner.md
# sseg_scanner

Multiplexed seven-segment display driver: the consumer end of the stopwatch's `bcd_digit` counter chain. It snapshots the packed BCD digit vector once per display frame so a rippling carry never tears the display. It then scans the digits one at a time onto a common-anode display, with optional leading-zero blanking and an anode dead time against ghosting. It sits between the counter chain and the board's display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned (1..8).
- `REFRESH_DIV`, 50000: clock cycles per digit slot (≥2).
- `DEAD_CYCLES`, 2: cycles at the start of each slot with all anodes off (< `REFRESH_DIV`).

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `digits`  in  4*NUM_DIGITS  packed BCD; `digits[3:0]` is digit 0 (least significant, rightmost).
- `dp_in`  in  NUM_DIGITS  decimal point request per digit, active-high.
- `blank_lz`  in  1  leading-zero blanking enable; sampled with the snapshot.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  NUM_DIGITS  digit anodes, active-low, one-hot-or-none.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1. On wrap, slot index `idx` advances 0→1→…→NUM_DIGITS-1→0.
- **Frame snapshot.** On the edge where `cnt==REFRESH_DIV-1` and `idx==NUM_DIGITS-1`, register `digits`, `dp_in` and `blank_lz`. Input changes at any other time are invisible until the next frame boundary.
- **Leading-zero blanking.** With snapshot `blank_lz=1`, digit i>0 is blanked (`seg=7'h7F`) when snapshot digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked. Blanking does not suppress the digit's `dp`.
- **Decode, active-low:**
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Codes 10–15 = 3F (segment g only, "-").
- **Anode drive.** While `cnt < DEAD_CYCLES`, `an` is all ones and `seg`/`dp` are blank. Otherwise `an[idx]=0`, `seg` is the decode of snapshot digit idx, and `dp = ~snapshot dp_in[idx]`.
- **No state machine beyond the counters.** Frame and slot sequencing are fully determined by `cnt`/`idx`.

## Timing
- **Reset values (asynchronous):**
  - Outputs: `an` all ones, `seg=7'h7F`, `dp=1`.
  - Internal state: `cnt=0`, `idx=0`, snapshot digits 0, snapshot dp 0, snapshot `blank_lz` 0.
- `seg`, `dp` and `an` are registered. They reflect the (`cnt`, `idx`, snapshot) state of the previous cycle, i.e. one cycle of latency.
- The first frame after reset displays the zero snapshot: "0000" with no blanking. Live data appears from the second frame.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Each anode is low for REFRESH_DIV-DEAD_CYCLES consecutive cycles per frame.
- Reset asserted mid-slot forces the reset values immediately. Scanning restarts at idx 0 with `cnt=0` on the first edge after release.
- If `digits` changes on the snapshot edge itself, the value present at that edge is captured.

## Structure
- **Package `sseg_pkg`:**
  - The ten digit segment constants and the `SEG_DASH` (3F) and `SEG_BLANK` (7F) constants.
  - Digit and segment width constants.
- **Sub-module `bcd_to_sseg`:** purely combinational 4-bit to 7-bit decoder, instantiated once on the muxed snapshot digit.
- **Top level:**
  - Prescaler, index counter, snapshot registers and blanking logic.
  - Output registers.

## Test plan
All scenarios use `NUM_DIGITS=4`, `REFRESH_DIV=4`, `DEAD_CYCLES=1`.
- **Reset:** reset low → `an=4'hF`, `seg=7'h7F`, `dp=1` immediately. After release, first frame shows `seg=40` on each anode in turn. `an` sequence per slot is F,E,E,E then F,D,D,D and so on.
- **Basic decode:** `digits=16'h1234`, `dp_in=4'b0100`, `blank_lz=0` → in the second frame:
  - `an=E`: `seg=19`.
  - `an=D`: `seg=30`.
  - `an=B`: `seg=24`, `dp=0`.
  - `an=7`: `seg=79`.
- **Leading-zero blanking:** `digits=16'h0042`, `blank_lz=1` → digits 3 and 2 show `7F`, digit 1 shows `19`, digit 0 shows `24`. With `digits=16'h0000`, only digit 0 shows `40`.
- **Invalid code:** `digits=16'hA0F5` → `3F`, `40`, `3F`, `12` on digits 3..0.
- **Tear-free update:** change `digits` from `16'h0009` to `16'h0010` while `idx=1` → remainder of the frame still shows 0009. The next frame shows 0010.
- **Mid-operation reset:** reset pulse while `idx=2` → outputs blank at once. After release, `idx` restarts at 0 and the snapshot is zero for one frame.
